counter_timer: RTL and testbench
================================

Name: counter_timer

Overview:
- Parametrised successor to the team's fixed 91-cycle load/done counter.
- Programmable terminal count N loaded with `ld`, a count-enable, and one-shot or periodic mode.
- Adds a synchronous cancel, a busy flag and a count readout.
- Used as the generic timeout/interval timer for control blocks that today instantiate fixed-count counters.

Parameters:
- WIDTH, 7, counter and load-value width. N ranges over 0..2^WIDTH-1.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- ld  input  1  load/start. Captures `n` and `mode` this cycle.
- n  input  WIDTH  terminal count, sampled only when ld=1.
- mode  input  1  0 = one-shot, 1 = periodic. Sampled only when ld=1.
- en  input  1  count enable. Cycles with en=0 are not counted.
- clr  input  1  synchronous cancel. Disarms the timer.
- dn  output  1  done (see Behaviour).
- busy  output  1  armed and count not yet expired.
- cnt  output  WIDTH  current remaining count.

Behaviour:
- Interface (already decided): one clock `clk`; reset `rst_n` is asynchronous and active-low.
- State registers: `armed` (1 bit), `cnt_q` (WIDTH), `n_q` (WIDTH), `mode_q` (1).
- Reset (rst_n=0, asynchronous):
  - armed=0, cnt_q=0, n_q=0, mode_q=0.
  - Outputs: dn=0, busy=0, cnt=0.
  - Reset may be asserted mid-count; the timer is idle afterwards and waits for the next ld.
- Load (ld=1 at cycle t):
  - Next edge: cnt_q<=n, n_q<=n, mode_q<=mode, armed<=1.
  - Overrides any count in progress (restart).
- Command priority: ld > clr > count.
- Clear: clr=1 with ld=0 sets armed<=0 and cnt_q<=0 at the next edge.
- Count: on an edge where armed=1, en=1, ld=0, clr=0 and cnt_q!=0, cnt_q<=cnt_q-1.
  - No wrap: cnt_q saturates at 0 in one-shot mode.
- Outputs (combinational from registers and ld):
  - dn = ~ld & armed & (cnt_q==0).
  - busy = armed & (cnt_q!=0).
  - cnt = cnt_q.
  - In the ld cycle, dn=0 regardless of the prior state.
- One-shot contract (mode_q=0):
  - Given ld=1 only at t (no ld/clr in t+1..t+k), dn at t+k holds iff #{cycles in t+1..t+k-1 with en=1} >= N.
  - With en tied high this reduces to: dn(t+k) iff N < k. This generalises the fixed-count property.
  - Once high, dn stays high until the next ld, clr or reset.
- Periodic mode (mode_q=1):
  - While armed and cnt_q==0, dn=1 (tick).
  - On an edge where that holds with en=1, ld=0, clr=0: cnt_q<=n_q (reload).
  - With en held high, dn is a 1-cycle pulse every N+1 cycles; the first pulse is at t+N+1.
  - If en=0 during a tick, dn holds high until the first enabled cycle, then reloads.
  - N=0 gives dn=1 continuously (reload to 0 every cycle).
- Boundary cases:
  - N=0 one-shot: dn at t+1.
  - N=2^WIDTH-1: full range, no overflow.
  - ld and clr in the same cycle: load wins.
  - en=0 freezes cnt_q only. ld and clr still act regardless of en.

Decomposition:
- Package counter_timer_pkg holds:
  - MODE_ONESHOT=1'b0 and MODE_PERIODIC=1'b1.
  - A typedef for the WIDTH-bit count vector (parametrised via the module).
- Sub-module sat_down_counter (WIDTH):
  - Inputs load/value/dec/clear; outputs count and zero flag.
  - Holds the loadable saturating decrementer.
  - counter_timer wraps it with arming, mode, reload and output logic.

Test Plan:
- Reset with WIDTH=7: rst_n=0 mid-count (cnt=40) -> dn=0, busy=0, cnt=0 immediately. Idle until ld.
- One-shot regression: ld at t with n=91, mode=0, en=1 -> dn=0 for k=0..91, dn=1 at k=92 and held through k=200. busy=1 for k=1..91.
- Enable gating: n=5, en pattern 1,0,0,1,1,1,1 from t+1 -> dn first high at t+8, cnt frozen at 4 during the en=0 cycles.
- Periodic: n=3, mode=1, en=1 -> dn pulses at t+4, t+8, t+12; cnt sequence 3,2,1,0,3,2,1,0.
- Priority/restart: ld and clr together at cnt=10 with n=20 -> cnt=20 next cycle, armed. clr alone later -> dn=0, busy=0, cnt=0.
- Edge values: n=0 one-shot -> dn at t+1. n=127 one-shot -> dn at t+128, no wrap after 300 cycles.

Source files
------------

// File: rtl/counter_timer_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : counter_timer_pkg                                             |
// | Purpose  : Shared constants and types for the programmable counter/timer.|
// |            Mode encodings and the default count width/vector type.       |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
package counter_timer_pkg;

   // Timer operating modes, captured together with the terminal count on ld.
   localparam logic MODE_ONESHOT  = 1'b0;
   localparam logic MODE_PERIODIC = 1'b1;

   // Default counter width; instances override it via their WIDTH parameter.
   localparam int DEF_WIDTH = 7;

   // Count vector at the default width. Modules declare their own vector type
   // from WIDTH so that non-default instances stay self-consistent.
   typedef logic [DEF_WIDTH-1:0] count_t;

endpackage : counter_timer_pkg
`default_nettype wire

// File: rtl/sat_down_counter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : sat_down_counter                                              |
// | Purpose  : Loadable down-counter that saturates at zero.                 |
// |            Priority: load > clear > dec. Decrement at zero is ignored.   |
// | Ports    : clk, rst_n      clock / async active-low reset                |
// |            load, value     load 'value' on the next edge                 |
// |            dec             decrement request (ignored at zero)           |
// |            clear           force count to zero on the next edge          |
// |            count, zero     current count and (count == 0) flag           |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module sat_down_counter #(
   parameter int WIDTH = 7
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load,
   input  logic [WIDTH-1:0] value,
   input  logic             dec,
   input  logic             clear,
   output logic [WIDTH-1:0] count,
   output logic             zero
);

   localparam logic [WIDTH-1:0] C_ONE = {{(WIDTH-1){1'b0}}, 1'b1};

   logic [WIDTH-1:0] r_count;
   logic             w_zero;

   assign w_zero = (r_count == '0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_count <= '0;
      end else if (load) begin
         r_count <= value;
      end else if (clear) begin
         r_count <= '0;
      end else if (dec && !w_zero) begin
         // Saturate at zero: never wrap to all-ones.
         r_count <= r_count - C_ONE;
      end
   end

   assign count = r_count;
   assign zero  = w_zero;

endmodule : sat_down_counter
`default_nettype wire

// File: rtl/counter_timer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : counter_timer                                                 |
// | Purpose  : Programmable timeout / interval timer. ld arms the timer with |
// |            terminal count n in one-shot or periodic mode; en gates       |
// |            counting; clr disarms. Command priority: ld > clr > count.    |
// | Ports    : clk, rst_n   clock / async active-low reset                   |
// |            ld, n, mode  load/start with terminal count and mode          |
// |            en           count enable                                     |
// |            clr          synchronous cancel                               |
// |            dn           done / periodic tick                             |
// |            busy         armed with count not yet expired                 |
// |            cnt          current remaining count                          |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module counter_timer
   import counter_timer_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             ld,
   input  logic [WIDTH-1:0] n,
   input  logic             mode,
   input  logic             en,
   input  logic             clr,
   output logic             dn,
   output logic             busy,
   output logic [WIDTH-1:0] cnt
);

   typedef logic [WIDTH-1:0] cnt_vec_t;

   logic     r_armed;
   cnt_vec_t r_n;
   logic     r_mode;

   cnt_vec_t w_count;
   logic     w_zero;
   logic     w_step;     // an edge on which the armed timer may advance
   logic     w_reload;   // periodic tick consumed: restart from r_n
   logic     w_cnt_load;
   cnt_vec_t w_cnt_value;
   logic     w_cnt_dec;
   logic     w_cnt_clear;

   // Counting only happens when no command is pending and the timer is armed.
   assign w_step      = r_armed & en & ~ld & ~clr;
   assign w_reload    = w_step & w_zero & (r_mode == MODE_PERIODIC);

   assign w_cnt_load  = ld | w_reload;
   assign w_cnt_value = ld ? n : r_n;
   assign w_cnt_dec   = w_step;
   assign w_cnt_clear = ~ld & clr;

   sat_down_counter #(
      .WIDTH (WIDTH)
   ) u_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .load  (w_cnt_load),
      .value (w_cnt_value),
      .dec   (w_cnt_dec),
      .clear (w_cnt_clear),
      .count (w_count),
      .zero  (w_zero)
   );

   // Arming, captured terminal count and mode.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_armed <= 1'b0;
         r_n     <= '0;
         r_mode  <= MODE_ONESHOT;
      end else if (ld) begin
         r_armed <= 1'b1;
         r_n     <= n;
         r_mode  <= mode;
      end else if (clr) begin
         r_armed <= 1'b0;
      end
   end

   // dn is masked in the ld cycle so a restart never shows a stale done.
   assign dn   = ~ld & r_armed & w_zero;
   assign busy = r_armed & ~w_zero;
   assign cnt  = w_count;

endmodule : counter_timer
`default_nettype wire

// File: tb/tb_counter_timer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_counter_timer                                              |
// | Purpose  : Self-checking bench for counter_timer (WIDTH=7). Expected     |
// |            outputs are queued when each cycle's stimulus is applied and  |
// |            popped/compared when the DUT outputs are sampled.             |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module tb_counter_timer;

   localparam int W = 7;

   logic         clk;
   logic         rst_n;
   logic         ld;
   logic [W-1:0] n;
   logic         mode;
   logic         en;
   logic         clr;
   logic         dn;
   logic         busy;
   logic [W-1:0] cnt;

   counter_timer #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .ld    (ld),
      .n     (n),
      .mode  (mode),
      .en    (en),
      .clr   (clr),
      .dn    (dn),
      .busy  (busy),
      .cnt   (cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic         dn;
      logic         busy;
      logic [W-1:0] cnt;
   } exp_t;

   exp_t exp_q[$];

   int total = 0;
   int bad   = 0;

   // Reference state of the timer, kept at the behavioural level.
   logic   m_armed;
   int     m_cnt;
   int     m_n;
   logic   m_mode;

   // Last sampled DUT outputs, for the directed milestone checks.
   logic   s_dn;
   logic   s_busy;
   int     s_cnt;

   task automatic chk(input string tag, input int got, input int expv);
      total++;
      if (got !== expv) begin
         bad++;
         $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, expv, $time);
      end
   endtask

   task automatic model_reset();
      m_armed = 1'b0;
      m_cnt   = 0;
      m_n     = 0;
      m_mode  = 1'b0;
   endtask

   // One clock cycle: drive inputs, queue expectations, sample at negedge,
   // then advance the reference across the rising edge.
   task automatic step(input logic i_ld, input int i_n, input logic i_mode,
                       input logic i_en, input logic i_clr);
      exp_t e;
      exp_t g;
      ld   = i_ld;
      n    = W'(i_n);
      mode = i_mode;
      en   = i_en;
      clr  = i_clr;
      e.dn   = !i_ld && m_armed && (m_cnt == 0);
      e.busy = m_armed && (m_cnt != 0);
      e.cnt  = W'(m_cnt);
      exp_q.push_back(e);
      @(negedge clk);
      g = exp_q.pop_front();
      s_dn   = dn;
      s_busy = busy;
      s_cnt  = int'(cnt);
      chk("dn",   int'(dn),   int'(g.dn));
      chk("busy", int'(busy), int'(g.busy));
      chk("cnt",  int'(cnt),  int'(g.cnt));
      @(posedge clk);
      if (i_ld) begin
         m_cnt   = i_n;
         m_n     = i_n;
         m_mode  = i_mode;
         m_armed = 1'b1;
      end else if (i_clr) begin
         m_armed = 1'b0;
         m_cnt   = 0;
      end else if (m_armed && i_en) begin
         if (m_cnt > 0)
            m_cnt = m_cnt - 1;
         else if (m_mode)
            m_cnt = m_n;
      end
      #1;
   endtask

   task automatic idle(input logic i_en);
      step(1'b0, 0, 1'b0, i_en, 1'b0);
   endtask

   initial begin
      automatic logic en_pat[7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
      rst_n = 1'b0;
      ld    = 1'b0;
      n     = '0;
      mode  = 1'b0;
      en    = 1'b0;
      clr   = 1'b0;
      model_reset();
      @(posedge clk);
      #1;
      chk("rst_dn",   int'(dn),   0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_cnt",  int'(cnt),  0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      idle(1'b1);
      idle(1'b1);

      // One-shot N=91 with en held high: done first at k=92, then held.
      step(1'b1, 91, 1'b0, 1'b1, 1'b0);
      for (int k = 1; k <= 200; k++) begin
         idle(1'b1);
         if (k == 1)   chk("os91_busy_k1", int'(s_busy), 1);
         if (k == 91)  chk("os91_dn_k91",  int'(s_dn),   0);
         if (k == 91)  chk("os91_busy_k91", int'(s_busy), 1);
         if (k == 92)  chk("os91_dn_k92",  int'(s_dn),   1);
         if (k == 200) chk("os91_dn_k200", int'(s_dn),   1);
      end

      // Enable gating: N=5, en 1,0,0,1,1,1,1 -> done first at t+8.
      step(1'b1, 5, 1'b0, 1'b1, 1'b0);
      for (int k = 1; k <= 7; k++) begin
         step(1'b0, 0, 1'b0, en_pat[k-1], 1'b0);
         if (k == 3) chk("gate_cnt_frozen", s_cnt, 4);
         if (k == 7) chk("gate_dn_k7", int'(s_dn), 0);
      end
      idle(1'b1);
      chk("gate_dn_k8", int'(s_dn), 1);

      // Periodic N=3: ticks at t+4, t+8, t+12.
      step(1'b1, 3, 1'b1, 1'b1, 1'b0);
      for (int k = 1; k <= 12; k++) begin
         idle(1'b1);
         if (k % 4 == 0) chk("per_tick", int'(s_dn), 1);
         if (k == 5)     chk("per_reload", s_cnt, 3);
      end

      // Periodic tick held while en=0, then reload on first enabled cycle.
      step(1'b1, 1, 1'b1, 1'b1, 1'b0);
      idle(1'b1);
      idle(1'b0);
      idle(1'b0);
      chk("per_hold_dn", int'(s_dn), 1);
      idle(1'b1);
      idle(1'b1);
      chk("per_hold_reload", s_cnt, 1);

      // Priority: ld+clr at cnt=10 -> restart with n=20; later clr alone.
      step(1'b1, 15, 1'b0, 1'b1, 1'b0);
      for (int k = 1; k <= 5; k++) idle(1'b1);
      step(1'b1, 20, 1'b0, 1'b1, 1'b1);
      chk("prio_pre_cnt", s_cnt, 10);
      idle(1'b1);
      chk("prio_cnt", s_cnt, 20);
      chk("prio_busy", int'(s_busy), 1);
      idle(1'b1);
      step(1'b0, 0, 1'b0, 1'b1, 1'b1);
      idle(1'b1);
      chk("clr_busy", int'(s_busy), 0);
      chk("clr_dn",   int'(s_dn),   0);

      // N=0 one-shot: done at t+1.
      step(1'b1, 0, 1'b0, 1'b1, 1'b0);
      idle(1'b1);
      chk("n0_dn", int'(s_dn), 1);

      // N=127 one-shot: done at t+128, no wrap afterwards.
      step(1'b1, 127, 1'b0, 1'b1, 1'b0);
      for (int k = 1; k <= 300; k++) begin
         idle(1'b1);
         if (k == 127) chk("n127_dn_k127", int'(s_dn), 0);
         if (k == 128) chk("n127_dn_k128", int'(s_dn), 1);
         if (k == 300) chk("n127_cnt_k300", s_cnt, 0);
      end

      // Asynchronous reset mid-count at cnt=40.
      step(1'b1, 60, 1'b0, 1'b1, 1'b0);
      for (int k = 1; k <= 20; k++) idle(1'b1);
      chk("pre_rst_cnt", int'(cnt), 40);
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_dn",   int'(dn),   0);
      chk("arst_busy", int'(busy), 0);
      chk("arst_cnt",  int'(cnt),  0);
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      for (int k = 1; k <= 5; k++) idle(1'b1);
      chk("post_rst_idle", int'(s_dn), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule : tb_counter_timer
`default_nettype wire
